// File: rtl/decode_issue_if.sv
// decode_issue_if: instruction, writeback and issue-bundle signals of the decode/issue stage
interface decode_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] x;
  logic [31:0] y;
  logic        alu_sel;
  logic [4:0]  rd;
  logic        illegal;
  modport master (
    output in_valid, in_instr, wb_en, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, funct3, funct7, x, y, alu_sel, rd, illegal
  );
  modport slave (
    input  in_valid, in_instr, wb_en, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, funct3, funct7, x, y, alu_sel, rd, illegal
  );
endinterface

// File: rtl/decode_issue_stage.sv
// decode_issue_stage: RV32I OP/OP-IMM decode, register read with busy scoreboard, registered issue to the ALU
module decode_issue_stage #(
  parameter bit BYPASS        = 1'b1,
  parameter bit ILLEGAL_STALL = 1'b0
) (
  input logic clk,
  input logic rst,
  decode_issue_if.slave bus
);
  logic [31:0] rf [32];
  logic [31:0] busy, busy_n;
  logic        stuck;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rs1, rs2, dst;
  logic        is_op, is_imm, shift, bad, wb, hit1, hit2, hazard, acc, issue;
  logic [31:0] v1, v2, imm;
  assign opc    = bus.in_instr[6:0];
  assign dst    = bus.in_instr[11:7];
  assign f3     = bus.in_instr[14:12];
  assign rs1    = bus.in_instr[19:15];
  assign rs2    = bus.in_instr[24:20];
  assign f7     = bus.in_instr[31:25];
  assign is_op  = opc == 7'b0110011;
  assign is_imm = opc == 7'b0010011;
  assign shift  = f3[1:0] == 2'b01;
  assign bad    = !(is_imm || (is_op && (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))));
  assign imm    = shift ? {27'b0, rs2} : {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
  // x0 is never written, so rf[0] stays zero and busy[0] stays clear
  assign wb     = bus.wb_en && bus.wb_rd != 5'd0;
  assign hit1   = BYPASS && wb && bus.wb_rd == rs1;
  assign hit2   = BYPASS && wb && bus.wb_rd == rs2;
  assign v1     = hit1 ? bus.wb_data : rf[rs1];
  assign v2     = hit2 ? bus.wb_data : rf[rs2];
  assign hazard = (busy[rs1] && !hit1) || (is_op && busy[rs2] && !hit2);
  assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !hazard && !stuck;
  assign acc    = bus.in_valid && bus.in_ready;
  assign issue  = acc && !bad;
  // a new reservation wins over a same-cycle writeback clear of the same register
  always_comb begin
    busy_n = busy;
    if (wb) busy_n[bus.wb_rd] = 1'b0;
    if (issue && dst != 5'd0) busy_n[dst] = 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
      busy          <= '0;
      stuck         <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.illegal   <= 1'b0;
      bus.funct3    <= '0;
      bus.funct7    <= '0;
      bus.x         <= '0;
      bus.y         <= '0;
      bus.alu_sel   <= 1'b0;
      bus.rd        <= '0;
    end else begin
      if (wb) rf[bus.wb_rd] <= bus.wb_data;
      busy        <= busy_n;
      stuck       <= stuck || (ILLEGAL_STALL && acc && bad);
      bus.illegal <= acc && bad;
      if (issue) begin
        bus.out_valid <= 1'b1;
        bus.funct3    <= f3;
        bus.funct7    <= (is_op || shift) ? f7 : 7'h00;
        bus.x         <= v1;
        bus.y         <= is_imm ? imm : v2;
        bus.alu_sel   <= is_imm;
        bus.rd        <= dst;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_decode_issue_stage.sv
// tb_decode_issue_stage: directed vector table, async-reset sequence and randomized run against a reference model
module tb_decode_issue_stage;
  localparam bit BYPASS = 1'b1;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  decode_issue_if bus();
  decode_issue_stage #(.BYPASS(BYPASS), .ILLEGAL_STALL(1'b0)) dut (.clk(clk), .rst(rst), .bus(bus));
  int tests = 0;
  int fails = 0;
  logic [31:0] mrf [32];
  bit   [31:0] mbusy;
  logic        mv, msel, mill;
  logic [2:0]  mf3;
  logic [6:0]  mf7;
  logic [31:0] mx, my;
  logic [4:0]  mrd;
  typedef struct {
    logic iv; logic [31:0] ins; logic we; logic [4:0] wr; logic [31:0] wd; logic ordy;
    logic rdy; logic v; logic [31:0] x; logic [31:0] y; logic [2:0] f3; logic [6:0] f7;
    logic sel; logic [4:0] rd; logic ill;
  } vec_t;
  vec_t tbl [17];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic m_reset();
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    mbusy = '0;
    {mv, msel, mill, mf3, mf7, mx, my, mrd} = '0;
  endtask
  function automatic logic fwd(input logic we, input logic [4:0] wr, input logic [4:0] r);
    return BYPASS && we && wr != 0 && wr == r;
  endfunction
  function automatic logic m_ready(input logic [31:0] ins, input logic we, input logic [4:0] wr, input logic ordy);
    logic stall1, stall2;
    stall1 = mbusy[ins[19:15]] && !fwd(we, wr, ins[19:15]);
    stall2 = ins[6:0] == 7'h33 && mbusy[ins[24:20]] && !fwd(we, wr, ins[24:20]);
    return (!mv || ordy) && !stall1 && !stall2;
  endfunction
  task automatic m_update(input logic iv, input logic [31:0] ins, input logic we, input logic [4:0] wr,
                          input logic [31:0] wd, input logic ordy, input logic rdy);
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] a, b;
    logic ok_op, ok_imm, acc;
    f3 = ins[14:12];
    f7 = ins[31:25];
    a = fwd(we, wr, ins[19:15]) ? wd : mrf[ins[19:15]];
    b = fwd(we, wr, ins[24:20]) ? wd : mrf[ins[24:20]];
    ok_op = ins[6:0] == 7'h33 && (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
    ok_imm = ins[6:0] == 7'h13;
    acc = iv && rdy;
    mill = acc && !(ok_op || ok_imm);
    if (acc && (ok_op || ok_imm)) begin
      mv = 1; mf3 = f3; mx = a; mrd = ins[11:7]; msel = ok_imm;
      if (ok_op) begin my = b; mf7 = f7; end
      else if (f3 == 1 || f3 == 5) begin my = 32'(ins[24:20]); mf7 = f7; end
      else begin my = 32'($signed({ins[31:20], 20'h0}) >>> 20); mf7 = 0; end
    end else if (ordy) mv = 0;
    if (we && wr != 0) begin mrf[wr] = wd; mbusy[wr] = 0; end
    if (acc && (ok_op || ok_imm) && ins[11:7] != 0) mbusy[ins[11:7]] = 1;
  endtask
  task automatic step(input logic iv, input logic [31:0] ins, input logic we, input logic [4:0] wr,
                      input logic [31:0] wd, input logic ordy, output logic rdy);
    logic er;
    bus.in_valid = iv; bus.in_instr = ins; bus.wb_en = we; bus.wb_rd = wr; bus.wb_data = wd; bus.out_ready = ordy;
    #1;
    er = m_ready(ins, we, wr, ordy);
    rdy = bus.in_ready;
    chk("in_ready", rdy, er);
    @(posedge clk);
    m_update(iv, ins, we, wr, wd, ordy, er);
    @(negedge clk);
    chk("out_valid", bus.out_valid, mv);
    chk("illegal", bus.illegal, mill);
    chk("funct3", bus.funct3, mf3);
    chk("funct7", bus.funct7, mf7);
    chk("x", bus.x, mx);
    chk("y", bus.y, my);
    chk("alu_sel", bus.alu_sel, msel);
    chk("rd", bus.rd, mrd);
  endtask
  function automatic logic [31:0] rand_instr();
    logic [4:0] a, b, d;
    logic [2:0] f3;
    int k;
    a = 5'($urandom_range(7)); b = 5'($urandom_range(7)); d = 5'($urandom_range(7));
    f3 = 3'($urandom); k = $urandom_range(11);
    if (k < 6) return {((f3 == 0 || f3 == 5) && $urandom_range(1) == 1) ? 7'h20 : 7'h00, b, a, f3, d, 7'h33};
    if (k < 10) return (f3[1:0] == 2'b01) ? {($urandom_range(1) == 1) ? 7'h20 : 7'h00, b, a, f3, d, 7'h13}
                                          : {12'($urandom), a, f3, d, 7'h13};
    if (k == 10) return {25'($urandom), ($urandom_range(1) == 1) ? 7'h6F : 7'h03};
    return {7'h01, b, a, f3, d, 7'h33};
  endfunction
  initial begin
    logic r;
    tbl[0]  = '{0, 32'h0,        1, 1, 32'h5,        1, 1, 0, 0,     0,            0, 0,     0, 0, 0};
    tbl[1]  = '{0, 32'h0,        1, 2, 32'h7,        1, 1, 0, 0,     0,            0, 0,     0, 0, 0};
    tbl[2]  = '{1, 32'h002081B3, 0, 0, 0,            1, 1, 1, 5,     7,            0, 0,     0, 3, 0};
    tbl[3]  = '{1, 32'hFFF00213, 0, 0, 0,            1, 1, 1, 0,     32'hFFFFFFFF, 0, 0,     1, 4, 0};
    tbl[4]  = '{1, 32'h40325293, 0, 0, 0,            1, 0, 0, 0,     32'hFFFFFFFF, 0, 0,     1, 4, 0};
    tbl[5]  = '{1, 32'h40325293, 1, 4, 32'h11,       1, 1, 1, 32'h11, 3,           5, 7'h20, 1, 5, 0};
    tbl[6]  = '{1, 32'h00208333, 0, 0, 0,            1, 1, 1, 5,     7,            0, 0,     0, 6, 0};
    tbl[7]  = '{1, 32'h00208333, 0, 0, 0,            0, 0, 1, 5,     7,            0, 0,     0, 6, 0};
    tbl[8]  = tbl[7];
    tbl[9]  = tbl[7];
    tbl[10] = '{1, 32'h402083B3, 0, 0, 0,            1, 1, 1, 5,     7,            0, 7'h20, 0, 7, 0};
    tbl[11] = '{1, 32'h0000006F, 0, 0, 0,            1, 1, 0, 5,     7,            0, 7'h20, 0, 7, 1};
    tbl[12] = '{0, 32'h0,        0, 0, 0,            1, 1, 0, 5,     7,            0, 7'h20, 0, 7, 0};
    tbl[13] = '{0, 32'h0,        1, 0, 32'hDEADBEEF, 1, 1, 0, 5,     7,            0, 7'h20, 0, 7, 0};
    tbl[14] = '{1, 32'h00000333, 0, 0, 0,            1, 1, 1, 0,     0,            0, 0,     0, 6, 0};
    tbl[15] = '{1, 32'h40001333, 0, 0, 0,            1, 1, 0, 0,     0,            0, 0,     0, 6, 1};
    tbl[16] = '{0, 32'h0,        0, 0, 0,            1, 1, 0, 0,     0,            0, 0,     0, 6, 0};
    rst = 1;
    bus.in_valid = 0; bus.in_instr = 0; bus.wb_en = 0; bus.wb_rd = 0; bus.wb_data = 0; bus.out_ready = 0;
    m_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset illegal", bus.illegal, 0);
    chk("reset x", bus.x, 0);
    chk("reset rd", bus.rd, 0);
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].iv, tbl[i].ins, tbl[i].we, tbl[i].wr, tbl[i].wd, tbl[i].ordy, r);
      chk($sformatf("vec%0d in_ready", i), r, tbl[i].rdy);
      chk($sformatf("vec%0d out_valid", i), bus.out_valid, tbl[i].v);
      chk($sformatf("vec%0d x", i), bus.x, tbl[i].x);
      chk($sformatf("vec%0d y", i), bus.y, tbl[i].y);
      chk($sformatf("vec%0d funct3", i), bus.funct3, tbl[i].f3);
      chk($sformatf("vec%0d funct7", i), bus.funct7, tbl[i].f7);
      chk($sformatf("vec%0d alu_sel", i), bus.alu_sel, tbl[i].sel);
      chk($sformatf("vec%0d rd", i), bus.rd, tbl[i].rd);
      chk($sformatf("vec%0d illegal", i), bus.illegal, tbl[i].ill);
    end
    step(1, 32'h00100413, 0, 0, 0, 0, r);
    chk("pre-reset out_valid", bus.out_valid, 1);
    bus.in_valid = 1; bus.in_instr = 32'h000184B3; bus.out_ready = 1;
    #1;
    chk("pre-reset hazard x3", bus.in_ready, 0);
    rst = 1;
    #1;
    chk("async out_valid", bus.out_valid, 0);
    chk("async y", bus.y, 0);
    chk("async rd", bus.rd, 0);
    chk("async alu_sel", bus.alu_sel, 0);
    chk("async busy cleared", bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    m_reset();
    step(1, 32'h000184B3, 0, 0, 0, 1, r);
    chk("post-reset accept", r, 1);
    chk("post-reset rd", bus.rd, 9);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(4) != 0, rand_instr(), $urandom_range(1) == 1, 5'($urandom_range(7)), $urandom,
           $urandom_range(3) != 0, r);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- Decode/register-read stage sitting directly upstream of the ALU.
- Accepts one 32-bit RV32I instruction per handshake and decodes OP (0110011) and OP-IMM (0010011) instructions.
- Reads operands from an internal 32x32 register file and issues funct3/funct7/x/y/alu_sel/rd to the ALU through a registered valid/ready output.
- Owns the writeback port of the register file and a per-register busy scoreboard that stalls read-after-write hazards.

Parameters:
- BYPASS, 1, 1 = writeback data forwarded to same-cycle operand reads; 0 = no forwarding.
- ILLEGAL_STALL, 0, 1 = a decode error holds in_ready low until reset; 0 = drop the instruction and pulse illegal.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  instruction valid
- in_ready  output  1  stage can accept instruction
- in_instr  input  32  instruction word
- wb_en  input  1  register write enable
- wb_rd  input  5  write index
- wb_data  input  32  write data
- out_valid  output  1  issue bundle valid
- out_ready  input  1  ALU consumes bundle
- funct3  output  3  instr[14:12]
- funct7  output  7  see Behaviour
- x  output  32  rs1 value
- y  output  32  rs2 value, or sign-extended immediate
- alu_sel  output  1  1 = OP-IMM, 0 = OP
- rd  output  5  destination index
- illegal  output  1  one-cycle pulse on decode error

Behaviour:
- Reset is clk-independent. It clears all registers to 0, all busy bits, out_valid, illegal, and every output bundle field to 0.
- Register file: x0 reads 0 and writes to index 0 are ignored. Writes take effect on the clk edge when wb_en=1.
- Write clears busy[wb_rd] on the same edge.
- Operand read: rs1 = instr[19:15], rs2 = instr[24:20].
  - With BYPASS=1, a matching wb_rd!=0 with wb_en=1 in the same cycle supplies wb_data.
  - With BYPASS=0, the old register value is used and the hazard check treats the register as still busy.
- Hazard: stall when busy[rs1]=1, or when op=OP and busy[rs2]=1.
  - With BYPASS=1, a busy register whose writeback occurs this cycle does not stall.
  - x0 is never busy.
- in_ready = (!out_valid || out_ready) && !hazard && !stuck. Combinational from current inputs and state.
- Accept (in_valid && in_ready) on a valid opcode:
  - Output fields load on the next edge and out_valid=1.
  - If rd!=0, busy[rd] is set.
  - Set wins over a same-cycle clear of the same index.
- OP-IMM:
  - alu_sel=1; y = sign-extend(instr[31:20]).
  - funct3 001/101: y = {27'b0, instr[24:20]} and funct7 = instr[31:25].
  - Any other funct3: funct7 = 0.
- OP: alu_sel=0; y = rs2 value; funct7 = instr[31:25].
  - funct7 must be 0000000, or 0100000 for funct3 000/101; otherwise decode error.
- Decode error (other opcode, or bad OP funct7) on accept:
  - No issue, no busy change, illegal=1 for exactly one cycle.
  - With ILLEGAL_STALL=1, a sticky stuck flag is set.
- Output hold: while out_valid && !out_ready, all output fields are stable.
- Same-cycle out_ready and accept gives back-to-back issue with no bubble.
- out_ready with no accept clears out_valid.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 instruction per cycle absent hazards.
- Reset mid-operation: any pending bundle and busy state are discarded. No writeback is expected afterwards.

Test Plan:
1. Reset, then wb x1=5 and x2=7, then issue ADD x3,x1,x2 (0x002081B3) with out_ready=1 -> next cycle out_valid=1, x=5, y=7, funct3=0, funct7=0, alu_sel=0, rd=3, busy[3]=1.
2. Issue ADDI x4,x0,-1 (0xFFF00213) -> y=0xFFFFFFFF, alu_sel=1, funct7=0, x=0. Then SRAI x5,x4,3 (0x40325293) -> stalls until wb x4; with BYPASS=1, accepted in the wb cycle with x=wb_data, y=3, funct7=0x20.
3. out_ready=0 for 3 cycles after an issue while in_valid stays high -> outputs constant, in_ready=0; raising out_ready gives back-to-back issue.
4. Issue 0x0000006F (JAL), ILLEGAL_STALL=0 -> illegal pulses for 1 cycle, out_valid stays 0, next instruction is accepted normally.
5. wb_en=1, wb_rd=0, wb_data=0xDEADBEEF, then ADD x6,x0,x0 -> x=0, y=0.
6. Assert rst while out_valid=1 and busy[3]=1 -> outputs and busy cleared immediately, without waiting for a clk edge; a dependent instruction after reset is accepted without stall.
